// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, ALU and load write ports, and a load scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned PC_IDX    = 15,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     ra1,
    input  logic [ADDR_W-1:0]     ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  alu_we,
    input  logic [ADDR_W-1:0]     alu_wa,
    input  logic [DATA_W-1:0]     alu_wd,
    input  logic                  ld_issue,
    input  logic [ADDR_W-1:0]     ld_issue_a,
    output logic                  issue_ready,
    input  logic                  ld_we,
    input  logic [ADDR_W-1:0]     ld_wa,
    input  logic [DATA_W-1:0]     ld_wd,
    output logic                  stall,
    output logic [2**ADDR_W-1:0]  pending,
    output logic                  pc_wr,
    output logic [DATA_W-1:0]     pc_wd,
    output logic                  wr_conflict
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PC_OFF = DATA_W'(PC_OFFSET);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pending_q, pending_d;
    logic              pc_wr_q, pc_wr_d;
    logic [DATA_W-1:0] pc_wd_q, pc_wd_d;
    logic              wr_conflict_q, wr_conflict_d;

    logic alu_pc, ld_pc, same_addr, alu_arr, ld_arr, issue_ok;

    always_comb begin
        alu_pc    = alu_we && (alu_wa == PC_A);
        ld_pc     = ld_we && (ld_wa == PC_A);
        same_addr = alu_we && ld_we && (alu_wa == ld_wa);
        // Load data wins a same-address collision, so the ALU write is dropped.
        alu_arr   = alu_we && !alu_pc && !same_addr;
        ld_arr    = ld_we && !ld_pc;
    end

    // A returning load to the same register frees the slot for a new issue.
    always_comb begin
        issue_ok = (!pending_q[ld_issue_a] || (ld_we && (ld_wa == ld_issue_a)))
                   && (ld_issue_a != PC_A);
    end

    always_comb begin
        pending_d = pending_q;
        if (ld_we) pending_d[ld_wa] = 1'b0;
        if (ld_issue && issue_ok) pending_d[ld_issue_a] = 1'b1;
        pc_wr_d       = alu_pc || ld_pc;
        pc_wd_d       = ld_pc ? ld_wd : (alu_pc ? alu_wd : pc_wd_q);
        wr_conflict_d = same_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            pending_q     <= '0;
            pc_wr_q       <= 1'b0;
            pc_wd_q       <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            if (alu_arr) regs_q[alu_wa] <= alu_wd;
            if (ld_arr) regs_q[ld_wa] <= ld_wd;
            pending_q     <= pending_d;
            pc_wr_q       <= pc_wr_d;
            pc_wd_q       <= pc_wd_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (ra == PC_A) return pc_in + PC_OFF;
`ifdef REGFILE_SB_BYPASS_EN
        if (ld_we && (ld_wa == ra)) return ld_wd;
        if (alu_we && (alu_wa == ra)) return alu_wd;
`endif
        return regs_q[ra];
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
`ifdef REGFILE_SB_BYPASS_EN
        stall = (pending_q[ra1] && !(ld_we && (ld_wa == ra1)))
             || (pending_q[ra2] && !(ld_we && (ld_wa == ra2)));
`else
        stall = pending_q[ra1] || pending_q[ra2];
`endif
    end

    assign issue_ready = issue_ok;
    assign pending     = pending_q;
    assign pc_wr       = pc_wr_q;
    assign pc_wd       = pc_wd_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ra1, ra2;
    logic [31:0] rd1, rd2, pc_in;
    logic        alu_we;
    logic [3:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        ld_issue;
    logic [3:0]  ld_issue_a;
    logic        issue_ready;
    logic        ld_we;
    logic [3:0]  ld_wa;
    logic [31:0] ld_wd;
    logic        stall;
    logic [15:0] pending;
    logic        pc_wr;
    logic [31:0] pc_wd;
    logic        wr_conflict;

    int vectors = 0;
    int miscompares = 0;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    regfile_sb dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .pc_in(pc_in), .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .ld_issue(ld_issue), .ld_issue_a(ld_issue_a), .issue_ready(issue_ready),
        .ld_we(ld_we), .ld_wa(ld_wa), .ld_wd(ld_wd), .stall(stall), .pending(pending),
        .pc_wr(pc_wr), .pc_wd(pc_wd), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the driven inputs at the next rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ra1 = 4'd3; ra2 = 4'd0; pc_in = '0;
        alu_we = 1'b0; alu_wa = '0; alu_wd = '0;
        ld_issue = 1'b0; ld_issue_a = '0; ld_we = 1'b0; ld_wa = '0; ld_wd = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_rd1", rd1, 32'h0);
        check("reset_pending", pending, 32'h0);
        check("reset_pc_wr", pc_wr, 32'h0);
        check("reset_wr_conflict", wr_conflict, 32'h0);

        // Write r3, then reserve r9 while writing the PC alias.
        alu_we = 1'b1; alu_wa = 4'd3; alu_wd = 32'hDEADBEEF;
        tick();
        check("r3_written", rd1, 32'hDEADBEEF);
        ld_issue = 1'b1; ld_issue_a = 4'd9;
        alu_we = 1'b1; alu_wa = 4'd15; alu_wd = 32'h0000_0123;
        tick();
        ld_issue = 1'b0; alu_we = 1'b0;
        check("pre_reset_pending", pending, 32'h0000_0200);
        check("pre_reset_pc_wr", pc_wr, 32'h1);
        #3 reset = 1'b1;
        #1;
        check("async_reset_rd1", rd1, 32'h0);
        check("async_reset_pending", pending, 32'h0);
        check("async_reset_pc_wr", pc_wr, 32'h0);
        #1 reset = 1'b0;

        // Late load return after reset dropped the reservation.
        ld_we = 1'b1; ld_wa = 4'd9; ld_wd = 32'h99;
        tick();
        ld_we = 1'b0; ra1 = 4'd9;
        #1;
        check("late_load_data", rd1, 32'h99);
        check("late_load_pending", pending, 32'h0);

        // PC alias read and redirected write.
        pc_in = 32'h100; ra1 = 4'd15;
        #1;
        check("pc_read", rd1, 32'h108);
        alu_we = 1'b1; alu_wa = 4'd15; alu_wd = 32'h200;
        tick();
        alu_we = 1'b0;
        check("pc_wr_pulse", pc_wr, 32'h1);
        check("pc_wd_alu", pc_wd, 32'h200);
        check("pc_read_after_wr", rd1, 32'h108);
        tick();
        check("pc_wr_one_cycle", pc_wr, 32'h0);
        alu_we = 1'b1; alu_wa = 4'd15; alu_wd = 32'h300;
        ld_we = 1'b1; ld_wa = 4'd15; ld_wd = 32'h400;
        tick();
        alu_we = 1'b0; ld_we = 1'b0;
        check("pc_wd_load_wins", pc_wd, 32'h400);
        check("pc_conflict_pulse", wr_conflict, 32'h1);
        ld_issue_a = 4'd15;
        #1;
        check("pc_issue_not_ready", issue_ready, 32'h0);

        // Load hazard on r5.
        ld_issue = 1'b1; ld_issue_a = 4'd5;
        #1;
        check("issue_ready_free", issue_ready, 32'h1);
        tick();
        ld_issue = 1'b0; ra1 = 4'd0; ra2 = 4'd5;
        #1;
        check("hazard_stall", stall, 32'h1);
        check("hazard_pending", pending, 32'h0000_0020);
        ld_issue = 1'b1;
        #1;
        check("reissue_not_ready", issue_ready, 32'h0);
        ld_issue_a = 4'd6;
        tick();
        ld_issue = 1'b0;
        check("ignored_issue_r5", pending, 32'h0000_0060);
        ld_we = 1'b1; ld_wa = 4'd5; ld_wd = 32'h55;
        #1;
        check("return_rd2", rd2, Byp ? 32'h55 : 32'h0);
        check("return_stall", stall, Byp ? 32'h0 : 32'h1);
        tick();
        ld_we = 1'b0;
        check("after_return_rd2", rd2, 32'h55);
        check("after_return_stall", stall, 32'h0);
        check("after_return_pending", pending, 32'h0000_0040);

        // Same-address write conflict.
        alu_we = 1'b1; alu_wa = 4'd2; alu_wd = 32'h11;
        ld_we = 1'b1; ld_wa = 4'd2; ld_wd = 32'h22;
        tick();
        alu_we = 1'b0; ld_we = 1'b0; ra1 = 4'd2;
        #1;
        check("conflict_data", rd1, 32'h22);
        check("conflict_pulse", wr_conflict, 32'h1);
        tick();
        check("conflict_one_cycle", wr_conflict, 32'h0);

        // Re-issue on release of r7.
        ld_issue = 1'b1; ld_issue_a = 4'd7;
        tick();
        ld_we = 1'b1; ld_wa = 4'd7; ld_wd = 32'h7;
        #1;
        check("release_issue_ready", issue_ready, 32'h1);
        tick();
        ld_issue = 1'b0; ld_we = 1'b0; ra1 = 4'd7;
        #1;
        check("release_data", rd1, 32'h7);
        check("release_pending", pending, 32'h0000_00C0);
        check("release_stall", stall, 32'h1);

        // Same-cycle bypass and load-over-ALU priority.
        ra1 = 4'd4; ra2 = 4'd10;
        alu_we = 1'b1; alu_wa = 4'd4; alu_wd = 32'hA5;
        #1;
        check("bypass_alu", rd1, Byp ? 32'hA5 : 32'h0);
        tick();
        check("alu_written", rd1, 32'hA5);
        alu_wa = 4'd10; alu_wd = 32'hBB;
        ld_we = 1'b1; ld_wa = 4'd10; ld_wd = 32'hCC;
        #1;
        check("bypass_priority", rd2, Byp ? 32'hCC : 32'h0);
        tick();
        alu_we = 1'b0; ld_we = 1'b0;
        check("priority_written", rd2, 32'hCC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file with a load scoreboard, for the multi-cycle and pipelined datapath generations. It provides two combinational read ports and two synchronous write ports. The ALU port writes results that complete in the same cycle. The load port writes memory data that returns late. A per-register pending bitmap drives a hazard stall toward the control unit. The PC index reads as pc_in + PC_OFFSET; writes to the PC index are redirected to a branch strobe.

Parameters:
DATA_W, 32, datapath width in bits
ADDR_W, 4, register address width; NREGS = 2**ADDR_W
PC_IDX, 15, register index aliased to the program counter
PC_OFFSET, 8, value added to pc_in on reads of PC_IDX

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ra1  in  ADDR_W  read address, port 1
ra2  in  ADDR_W  read address, port 2
rd1  out  DATA_W  read data, port 1
rd2  out  DATA_W  read data, port 2
pc_in  in  DATA_W  current PC
alu_we  in  1  ALU write enable
alu_wa  in  ADDR_W  ALU write address
alu_wd  in  DATA_W  ALU write data
ld_issue  in  1  load issued; reserve ld_issue_a
ld_issue_a  in  ADDR_W  load destination register
issue_ready  out  1  ld_issue will be accepted this cycle
ld_we  in  1  load data returning
ld_wa  in  ADDR_W  load writeback address
ld_wd  in  DATA_W  load writeback data
stall  out  1  a read port addresses a pending register
pending  out  NREGS  scoreboard bitmap
pc_wr  out  1  registered strobe: a write targeted PC_IDX
pc_wd  out  DATA_W  registered data for pc_wr
wr_conflict  out  1  registered pulse: both write ports hit the same address

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - all NREGS registers are cleared to 0;
  - pending = 0;
  - pc_wr = 0, pc_wd = 0, wr_conflict = 0.
  - Reset mid-load drops the reservation. A later ld_we is still written, and clearing an already-clear bit is harmless.
- Reads are combinational:
  - rdN = pc_in + PC_OFFSET (modulo 2**DATA_W) when raN == PC_IDX;
  - otherwise rdN = reg[raN], or the bypassed value (see Optional Feature).
- Writes occur on the rising clk edge:
  - alu_we writes alu_wd to reg[alu_wa];
  - ld_we writes ld_wd to reg[ld_wa].
- Writes to PC_IDX do not touch the array. On the next edge pc_wr = 1 and pc_wd = the written data, for exactly one cycle. If both ports target PC_IDX, the load data wins.
- Same-address conflict (alu_we && ld_we && alu_wa == ld_wa): the load data is written and wr_conflict pulses high for one cycle.
- Scoreboard:
  - issue_ready = !pending[ld_issue_a] && ld_issue_a != PC_IDX.
  - ld_issue && issue_ready sets pending[ld_issue_a] at the edge. An issue with issue_ready = 0 is ignored entirely.
  - ld_we clears pending[ld_wa] at the edge.
  - If ld_we and an accepted ld_issue target the same address in the same cycle, the data is written and the bit stays set (set wins).
  - Exception: ld_we may release the same register that a new ld_issue targets. For that case issue_ready also goes 1 when ld_we && ld_wa == ld_issue_a.
- An ALU write to a pending register is performed. The pending bit is unchanged, so the load result still overwrites it later.
- stall is combinational: (pending[ra1] || pending[ra2]) && !(returning bypass, Optional Feature). PC_IDX is never pending.
- Latency: a write is visible on the read ports in the same cycle with the bypass, or in the next cycle without it.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: a read whose address matches an active write port in the same cycle returns the write data (load data takes priority). stall is suppressed for a pending register whose ld_we matches that cycle.
- Undefined: reads return array contents only. The stall suppression is removed, so a returning load stalls the reader for one extra cycle.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to r3, then assert reset asynchronously, mid-cycle -> rd1 = 0 immediately; pending = 0; pc_wr = 0.
- PC read and write: pc_in = 0x100, ra1 = 15 -> rd1 = 0x108. alu_we to r15 with 0x200 -> next cycle pc_wr = 1 and pc_wd = 0x200; a subsequent read of r15 is still pc_in + 8.
- Load hazard: ld_issue r5, read ra2 = 5 -> stall = 1 and a second ld_issue r5 gives issue_ready = 0. ld_we r5 = 0x55 returns -> pending[5] clears; rd2 = 0x55 (same cycle with the bypass, next cycle without).
- Write conflict: alu_we r2 = 0x11 and ld_we r2 = 0x22 in the same cycle -> r2 = 0x22 and wr_conflict pulses for one cycle.
- Re-issue on release: pending[7] set, then ld_we r7 = 0x7 and ld_issue r7 in the same cycle -> issue_ready = 1, r7 = 0x7, pending[7] stays 1.
- Bypass on/off: alu_we r4 = 0xA5 with ra1 = 4 in the same cycle -> rd1 = 0xA5 with the macro defined, old value without it.
